// File: rtl/sum_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : sum_collector_if
//  Description : Producer/consumer signal bundle for sum_collector. The slave
//                modport is the collector's view; the master modport is the
//                view of the block driving results and accepting entries.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sum_collector_if #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Producer side
    logic               In_Valid;
    logic [3:0]         Sum;
    logic               Overflow;

    // Consumer side
    logic               Out_Ready;
    logic               Out_Valid;
    logic [4:0]         Out_Data;

    // Status
    logic               Full;
    logic               Empty;
    logic [c_CNT_W-1:0] Count;
    logic [ACC_W-1:0]   Acc;
    logic               Acc_Sat;
    logic [7:0]         Drop_Cnt;

    modport slave (
        input  In_Valid, Sum, Overflow, Out_Ready,
        output Out_Valid, Out_Data, Full, Empty, Count, Acc, Acc_Sat, Drop_Cnt
    );

    modport master (
        output In_Valid, Sum, Overflow, Out_Ready,
        input  Out_Valid, Out_Data, Full, Empty, Count, Acc, Acc_Sat, Drop_Cnt
    );
endinterface
`default_nettype wire

// File: rtl/sum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sum_collector
//  Description : Captures {Overflow,Sum} adder results into a first-word-
//                fall-through FIFO with a valid/ready consumer port, keeps a
//                saturating running total of accepted results and a
//                saturating count of results dropped while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_collector #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
) (
    input  wire logic       Clk,
    input  wire logic       Reset,
    sum_collector_if.slave  bus
);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [4:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_sat;
    logic [7:0]         r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [4:0]         w_in_data;
    logic [ACC_W:0]     w_acc_sum;

    // Full/Empty come from the registered count, so a pop in the same cycle
    // never frees a slot for a push; push into an empty FIFO never pops.
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_in_data = {bus.Overflow, bus.Sum};
    assign w_push    = bus.In_Valid & ~w_full;
    assign w_drop    = bus.In_Valid & w_full;
    assign w_pop     = ~w_empty & bus.Out_Ready;
    assign w_acc_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_in_data);

    // Storage write; contents are never cleared, only the pointers are.
    always_ff @(posedge Clk) begin
        if (!Reset && w_push) begin
            r_mem[r_wptr] <= w_in_data;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating running total; once the extra carry bit fires the total
    // pins at all-ones and the sticky flag stays set until reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_push) begin
            if (w_acc_sum[ACC_W]) begin
                r_acc     <= '1;
                r_acc_sat <= 1'b1;
            end else begin
                r_acc     <= w_acc_sum[ACC_W-1:0];
            end
        end
    end

    // Saturating count of results rejected because the FIFO was full.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.Out_Valid = ~w_empty;
    assign bus.Out_Data  = r_mem[r_rptr];
    assign bus.Full      = w_full;
    assign bus.Empty     = w_empty;
    assign bus.Count     = r_count;
    assign bus.Acc       = r_acc;
    assign bus.Acc_Sat   = r_acc_sat;
    assign bus.Drop_Cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_collector
//  Description : Self-checking bench for sum_collector. Two instances share
//                stimulus: one with a 12-bit total and one with a 5-bit
//                total so saturation is reachable. A queue-based model
//                tracks the expected FIFO contents and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_collector;
    localparam int c_DEPTH = 4;

    logic       Clk;
    logic       Reset;
    logic       r_vld;
    logic [3:0] r_sum;
    logic       r_ovf;
    logic       r_rdy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sum_collector_if #(.DEPTH(c_DEPTH), .ACC_W(12)) bus12 ();
    sum_collector_if #(.DEPTH(c_DEPTH), .ACC_W(5))  bus5  ();

    assign bus12.In_Valid  = r_vld;
    assign bus12.Sum       = r_sum;
    assign bus12.Overflow  = r_ovf;
    assign bus12.Out_Ready = r_rdy;
    assign bus5.In_Valid   = r_vld;
    assign bus5.Sum        = r_sum;
    assign bus5.Overflow   = r_ovf;
    assign bus5.Out_Ready  = r_rdy;

    sum_collector #(.DEPTH(c_DEPTH), .ACC_W(12)) u_dut12 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus12)
    );

    sum_collector #(.DEPTH(c_DEPTH), .ACC_W(5)) u_dut5 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus5)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    logic [4:0] m_q[$];
    int         m_acc12 = 0;
    int         m_acc5  = 0;
    bit         m_sat12 = 1'b0;
    bit         m_sat5  = 1'b0;
    int         m_drop  = 0;

    always @(posedge Clk) begin
        bit full;
        bit pop;
        int v;
        if (Reset) begin
            m_q.delete();
            m_acc12 = 0;
            m_acc5  = 0;
            m_sat12 = 1'b0;
            m_sat5  = 1'b0;
            m_drop  = 0;
        end else begin
            full = (m_q.size() == c_DEPTH);
            pop  = (m_q.size() != 0) && r_rdy;
            if (r_vld && full) begin
                if (m_drop < 255) m_drop++;
            end
            if (pop) void'(m_q.pop_front());
            if (r_vld && !full) begin
                v = int'({r_ovf, r_sum});
                m_q.push_back({r_ovf, r_sum});
                if (m_acc12 + v > 4095) begin m_acc12 = 4095; m_sat12 = 1'b1; end
                else m_acc12 = m_acc12 + v;
                if (m_acc5 + v > 31) begin m_acc5 = 31; m_sat5 = 1'b1; end
                else m_acc5 = m_acc5 + v;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            chk("out_valid12", int'(bus12.Out_Valid), int'(m_q.size() != 0));
            chk("empty12",     int'(bus12.Empty),     int'(m_q.size() == 0));
            chk("full12",      int'(bus12.Full),      int'(m_q.size() == c_DEPTH));
            chk("count12",     int'(bus12.Count),     m_q.size());
            chk("acc12",       int'(bus12.Acc),       m_acc12);
            chk("acc_sat12",   int'(bus12.Acc_Sat),   int'(m_sat12));
            chk("drop12",      int'(bus12.Drop_Cnt),  m_drop);
            chk("count5",      int'(bus5.Count),      m_q.size());
            chk("acc5",        int'(bus5.Acc),        m_acc5);
            chk("acc_sat5",    int'(bus5.Acc_Sat),    int'(m_sat5));
            chk("drop5",       int'(bus5.Drop_Cnt),   m_drop);
            if (m_q.size() != 0) begin
                chk("out_data12", int'(bus12.Out_Data), int'(m_q[0]));
                chk("out_data5",  int'(bus5.Out_Data),  int'(m_q[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [4:0] d, input bit r);
        @(negedge Clk);
        Reset = 1'b0;
        r_vld = v;
        {r_ovf, r_sum} = d;
        r_rdy = r;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        r_vld = 1'b0;
        r_rdy = 1'b0;
        {r_ovf, r_sum} = 5'h00;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0;
        r_vld = 1'b0;
        r_rdy = 1'b0;
        {r_ovf, r_sum} = 5'h00;

        // Reset then idle
        do_reset();
        chk_en = 1'b1;
        step(0, 5'h00, 0);
        step(0, 5'h00, 0);
        chk("rst_empty",  int'(bus12.Empty), 1);
        chk("rst_valid",  int'(bus12.Out_Valid), 0);
        chk("rst_count",  int'(bus12.Count), 0);
        chk("rst_acc",    int'(bus12.Acc), 0);
        chk("rst_sat",    int'(bus12.Acc_Sat), 0);
        chk("rst_drop",   int'(bus12.Drop_Cnt), 0);

        // Fill and drain
        step(1, 5'h03, 0);
        step(1, 5'h1F, 0);
        step(1, 5'h10, 0);
        step(1, 5'h00, 0);
        step(0, 5'h00, 1);
        chk("fill_full",  int'(bus12.Full), 1);
        chk("fill_count", int'(bus12.Count), 4);
        chk("fill_acc",   int'(bus12.Acc), 32'h032);
        chk("drain_0",    int'(bus12.Out_Data), 32'h03);
        step(0, 5'h00, 1);
        chk("drain_1",    int'(bus12.Out_Data), 32'h1F);
        step(0, 5'h00, 1);
        chk("drain_2",    int'(bus12.Out_Data), 32'h10);
        step(0, 5'h00, 1);
        chk("drain_3",    int'(bus12.Out_Data), 32'h00);
        step(0, 5'h00, 0);
        chk("drain_empty", int'(bus12.Empty), 1);

        // Overflow drop: refill, then three pushes while full (last with pop)
        step(1, 5'h03, 0);
        step(1, 5'h1F, 0);
        step(1, 5'h10, 0);
        step(1, 5'h00, 0);
        step(1, 5'h07, 0);
        step(1, 5'h08, 0);
        step(1, 5'h09, 1);
        step(0, 5'h00, 1);
        chk("drop_cnt",   int'(bus12.Drop_Cnt), 3);
        chk("drop_acc",   int'(bus12.Acc), 32'h064);
        chk("drop_count", int'(bus12.Count), 3);
        chk("drop_head0", int'(bus12.Out_Data), 32'h1F);
        step(0, 5'h00, 1);
        chk("drop_head1", int'(bus12.Out_Data), 32'h10);
        step(0, 5'h00, 1);
        chk("drop_head2", int'(bus12.Out_Data), 32'h00);
        step(0, 5'h00, 0);
        chk("drop_empty", int'(bus12.Empty), 1);

        // Streaming with wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 5'(i + 1), 1);
            if (i > 0) begin
                chk("stream_data",  int'(bus12.Out_Data), i);
                chk("stream_count", int'(bus12.Count), 1);
            end
        end
        step(0, 5'h00, 1);
        chk("stream_last", int'(bus12.Out_Data), 20);
        step(0, 5'h00, 0);
        chk("stream_empty", int'(bus12.Empty), 1);

        // Saturation on the 5-bit instance
        do_reset();
        step(1, 5'h1F, 0);
        step(1, 5'h01, 0);
        step(0, 5'h00, 0);
        chk("sat_acc",   int'(bus5.Acc), 32'h1F);
        chk("sat_flag",  int'(bus5.Acc_Sat), 1);
        chk("nosat_acc", int'(bus12.Acc), 32'h020);
        step(1, 5'h00, 0);
        step(0, 5'h00, 0);
        chk("sat_hold_acc",  int'(bus5.Acc), 32'h1F);
        chk("sat_hold_flag", int'(bus5.Acc_Sat), 1);

        // Reset mid-operation: fill, drop twice, pop once -> count 3
        step(1, 5'h00, 0);
        step(1, 5'h00, 0);
        step(1, 5'h00, 0);
        step(0, 5'h00, 1);
        step(0, 5'h00, 0);
        chk("pre_rst_count", int'(bus12.Count), 3);
        chk("pre_rst_acc",   int'(bus12.Acc), 32'h020);
        chk("pre_rst_drop",  int'(bus12.Drop_Cnt), 2);
        @(negedge Clk);
        Reset = 1'b1;
        r_vld = 1'b1;
        {r_ovf, r_sum} = 5'h0A;
        r_rdy = 1'b1;
        step(0, 5'h00, 0);
        chk("mid_rst_valid", int'(bus12.Out_Valid), 0);
        chk("mid_rst_empty", int'(bus12.Empty), 1);
        chk("mid_rst_full",  int'(bus12.Full), 0);
        chk("mid_rst_count", int'(bus12.Count), 0);
        chk("mid_rst_acc",   int'(bus12.Acc), 0);
        chk("mid_rst_sat5",  int'(bus5.Acc_Sat), 0);
        chk("mid_rst_drop",  int'(bus12.Drop_Cnt), 0);
        step(0, 5'h00, 0);
        step(0, 5'h00, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
